// File: rtl/sample_delay_ram.sv
// sample_delay_ram: single-clock 1RW1R sample memory with byte write mask,
// selectable read latency (1 or 2), write-first bypass and a circular
// delay-line mode in which port 1 reads a tap d samples in the past.
module sample_delay_ram #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 14,
  parameter int NUM_WMASKS   = DATA_WIDTH/8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH:0]   fill,
  output logic                  collision
);
  localparam int RAM_DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   FULL  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] ONE_A = 1;
  localparam logic [ADDR_WIDTH:0]   ONE_F = 1;

  logic                  mode_q;
  logic                  wr_req, wr_go, rd0_req, rd1_req, silence, col_now;
  logic [ADDR_WIDTH-1:0] waddr, tap_w, raddr1;
  logic [ADDR_WIDTH:0]   tap_f;

  // valid/collision shift registers: bit k is the request k+1 edges old
  logic [READ_LATENCY:0] v0p, v1p, cp;

  // request side registered at the request edge, consumed at the next edge
  logic [ADDR_WIDTH-1:0] a0_s1, a1_s1;
  logic                  sil_s1;

  logic [DATA_WIDTH-1:0] rd0_w, rd1_w;

  // decode requests; in ring mode the tap is resolved against the pointer
  // state as it will be after this edge's write (W/F) so d=0 hits the new sample
  always_comb begin
    wr_req  = !csb0 && !web0;
    wr_go   = wr_req && (|wmask0);
    rd0_req = !csb0 && web0;
    rd1_req = !csb1;
    waddr   = mode_q ? wr_ptr : addr0;
    tap_w   = wr_go ? wr_ptr : wr_ptr - ONE_A;
    tap_f   = (wr_go && fill != FULL) ? fill + ONE_F : fill;
    raddr1  = addr1;
    silence = 1'b0;
    if (mode_q) begin
      raddr1  = tap_w - addr1;
      silence = ({1'b0, addr1} >= tap_f);
    end
    col_now = rd1_req && wr_req && !silence && (raddr1 == waddr);
  end

  // registered mode, ring pointer and fill; a mode change clears the ring
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= mode;
      wr_ptr <= '0;
      fill   <= '0;
    end else begin
      mode_q <= mode;
      if (mode != mode_q) begin
        wr_ptr <= '0;
        fill   <= '0;
      end else if (mode_q && wr_go) begin
        wr_ptr <= wr_ptr + ONE_A;
        fill   <= tap_f;
      end
    end
  end

  // valid pipes; reset drops every in-flight read
  always_ff @(posedge clk) begin
    if (rst) begin
      v0p <= '0;
      v1p <= '0;
      cp  <= '0;
    end else begin
      v0p <= {v0p[READ_LATENCY-1:0], rd0_req};
      v1p <= {v1p[READ_LATENCY-1:0], rd1_req};
      cp  <= {cp[READ_LATENCY-1:0], col_now};
    end
  end

  // capture read addresses; array is read one edge later, after the write
  always_ff @(posedge clk) begin
    a0_s1  <= addr0;
    a1_s1  <= raddr1;
    sil_s1 <= silence;
  end

  for (genvar b = 0; b < NUM_WMASKS; b++) begin : g_lane
    logic [7:0] mem [RAM_DEPTH];
    logic [7:0] lane_rd0, lane_rd1;

    // byte-lane write; reset blocks writes but never clears contents
    always_ff @(posedge clk) begin
      if (!rst && wr_req && wmask0[b])
        mem[waddr][7:0] <= din0[8*b +: 8];
    end

    // byte-lane read registers hold their value between reads
    always_ff @(posedge clk) begin
      if (rst) begin
        lane_rd0 <= '0;
        lane_rd1 <= '0;
      end else begin
        if (v0p[0]) lane_rd0 <= mem[a0_s1];
        if (v1p[0]) lane_rd1 <= sil_s1 ? 8'h00 : mem[a1_s1];
      end
    end

    assign rd0_w[8*b +: 8] = lane_rd0;
    assign rd1_w[8*b +: 8] = lane_rd1;
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] dout0_r, dout1_r;

    // extra output register for the two-cycle latency build
    always_ff @(posedge clk) begin
      if (rst) begin
        dout0_r <= '0;
        dout1_r <= '0;
      end else begin
        if (v0p[1]) dout0_r <= rd0_w;
        if (v1p[1]) dout1_r <= rd1_w;
      end
    end

    assign dout0 = dout0_r;
    assign dout1 = dout1_r;
  end else begin : g_lat1
    assign dout0 = rd0_w;
    assign dout1 = rd1_w;
  end

  assign dout0_valid = v0p[READ_LATENCY];
  assign dout1_valid = v1p[READ_LATENCY];
  assign collision   = cp[READ_LATENCY];
endmodule

// File: tb/tb_sample_delay_ram.sv
// Bench for sample_delay_ram: a latency-1 and a latency-2 instance share the
// same stimulus; a behavioural model predicts every output cycle by cycle.
module tb_sample_delay_ram;
  logic        clk, rst, mode, csb0, web0, csb1;
  logic [1:0]  wmask0;
  logic [3:0]  addr0, addr1;
  logic [15:0] din0;

  logic [15:0] u1_dout0, u1_dout1, u2_dout0, u2_dout1;
  logic        u1_v0, u1_v1, u1_col, u2_v0, u2_v1, u2_col;
  logic [3:0]  u1_wr_ptr, u2_wr_ptr;
  logic [4:0]  u1_fill, u2_fill;

  int checks = 0;
  int failures = 0;

  sample_delay_ram #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .READ_LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .mode(mode), .csb0(csb0), .web0(web0),
    .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(u1_dout0),
    .dout0_valid(u1_v0), .csb1(csb1), .addr1(addr1), .dout1(u1_dout1),
    .dout1_valid(u1_v1), .wr_ptr(u1_wr_ptr), .fill(u1_fill), .collision(u1_col));

  sample_delay_ram #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .READ_LATENCY(2)) u2 (
    .clk(clk), .rst(rst), .mode(mode), .csb0(csb0), .web0(web0),
    .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(u2_dout0),
    .dout0_valid(u2_v0), .csb1(csb1), .addr1(addr1), .dout1(u2_dout1),
    .dout1_valid(u2_v1), .wr_ptr(u2_wr_ptr), .fill(u2_fill), .collision(u2_col));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] mm [16];
  logic        m_mode;
  int          m_ptr, m_fill, n;
  logic        pv0 [3][8], pv1 [3][8], pc [3][8];
  logic [15:0] pd0 [3][8], pd1 [3][8];
  logic        ev0 [3], ev1 [3], ec [3];
  logic [15:0] ed0 [3], ed1 [3];
  logic        t_wreq, t_wgo, t_rd0, t_rd1, t_sil, t_col;
  int          t_waddr, t_w, t_f, t_a, s;
  logic [15:0] t_d0, t_d1;

  initial begin
    n = 0; m_mode = 0; m_ptr = 0; m_fill = 0;
    for (int l = 0; l < 3; l++) begin
      ev0[l] = 0; ev1[l] = 0; ec[l] = 0; ed0[l] = 0; ed1[l] = 0;
      for (int k = 0; k < 8; k++) begin
        pv0[l][k] = 0; pv1[l][k] = 0; pc[l][k] = 0; pd0[l][k] = 0; pd1[l][k] = 0;
      end
    end
    for (int k = 0; k < 16; k++) mm[k] = 16'h0;
  end

  // model steps once per rising edge using the inputs the bench drove
  always @(posedge clk) begin
    n = n + 1;
    if (rst) begin
      m_mode = mode; m_ptr = 0; m_fill = 0;
      for (int l = 1; l < 3; l++) begin
        ed0[l] = 0; ed1[l] = 0;
        for (int k = 0; k < 8; k++) begin pv0[l][k] = 0; pv1[l][k] = 0; pc[l][k] = 0; end
      end
    end else begin
      t_wreq  = !csb0 && !web0;
      t_wgo   = t_wreq && (wmask0 != 0);
      t_rd0   = !csb0 && web0;
      t_rd1   = !csb1;
      t_waddr = m_mode ? m_ptr : int'(addr0);
      if (t_wreq) begin
        if (wmask0[0]) mm[t_waddr][7:0]  = din0[7:0];
        if (wmask0[1]) mm[t_waddr][15:8] = din0[15:8];
      end
      t_sil = 0;
      t_a   = int'(addr1);
      if (m_mode) begin
        t_w   = t_wgo ? m_ptr : (m_ptr + 15) % 16;
        t_f   = t_wgo ? ((m_fill < 16) ? m_fill + 1 : 16) : m_fill;
        t_sil = int'(addr1) >= t_f;
        t_a   = (t_w - int'(addr1) + 16) % 16;
      end
      t_col = t_rd1 && t_wreq && !t_sil && (t_a == t_waddr);
      t_d0  = mm[addr0];
      t_d1  = t_sil ? 16'h0 : mm[t_a];
      for (int l = 1; l < 3; l++) begin
        s = (n + l) % 8;
        pv0[l][s] = t_rd0; pd0[l][s] = t_d0;
        pv1[l][s] = t_rd1; pd1[l][s] = t_d1;
        pc[l][s]  = t_col;
      end
      if (mode != m_mode) begin
        m_ptr = 0; m_fill = 0;
      end else if (m_mode && t_wgo) begin
        m_ptr  = (m_ptr + 1) % 16;
        m_fill = (m_fill < 16) ? m_fill + 1 : 16;
      end
      m_mode = mode;
    end
    for (int l = 1; l < 3; l++) begin
      s = n % 8;
      ev0[l] = pv0[l][s]; if (ev0[l]) ed0[l] = pd0[l][s]; pv0[l][s] = 0;
      ev1[l] = pv1[l][s]; if (ev1[l]) ed1[l] = pd1[l][s]; pv1[l][s] = 0;
      ec[l]  = pc[l][s];  pc[l][s] = 0;
    end
  end

  // compare both instances against the model away from the rising edge
  always @(negedge clk) begin
    if (n > 0) begin
      chk("u1_dout0_valid", u1_v0, ev0[1]);  chk("u2_dout0_valid", u2_v0, ev0[2]);
      chk("u1_dout1_valid", u1_v1, ev1[1]);  chk("u2_dout1_valid", u2_v1, ev1[2]);
      chk("u1_collision", u1_col, ec[1]);    chk("u2_collision", u2_col, ec[2]);
      chk("u1_dout0", u1_dout0, ed0[1]);     chk("u2_dout0", u2_dout0, ed0[2]);
      chk("u1_dout1", u1_dout1, ed1[1]);     chk("u2_dout1", u2_dout1, ed1[2]);
      chk("u1_wr_ptr", u1_wr_ptr, m_ptr);    chk("u2_wr_ptr", u2_wr_ptr, m_ptr);
      chk("u1_fill", u1_fill, m_fill);       chk("u2_fill", u2_fill, m_fill);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    csb0 = 1; web0 = 1; wmask0 = 0; csb1 = 1;
  endtask
  task automatic step();
    @(posedge clk); @(negedge clk);
  endtask
  task automatic wr(input int a, input int d, input logic [1:0] m);
    csb0 = 0; web0 = 0; addr0 = 4'(a); din0 = 16'(d); wmask0 = m;
  endtask
  task automatic rd0(input int a);
    csb0 = 0; web0 = 1; addr0 = 4'(a);
  endtask
  task automatic rd1(input int a);
    csb1 = 0; addr1 = 4'(a);
  endtask

  initial begin
    rst = 1; mode = 0; addr0 = 0; addr1 = 0; din0 = 0; idle();
    step(); step();
    chk("rst_dout0", u1_dout0, 0); chk("rst_fill", u1_fill, 0);
    chk("rst_valid", u1_v1, 0);
    rst = 0;

    // known contents: mem[a] = 0x1000 + a
    for (int a = 0; a < 16; a++) begin wr(a, 16'h1000 + a, 2'b11); step(); end
    idle(); step();

    // latency 2: back-to-back reads 1,2,3
    rd1(1); step(); rd1(2); step();
    chk("lat2_early_valid", u2_v1, 0);
    rd1(3); step(); idle();
    chk("lat2_v_a", u2_v1, 1); chk("lat2_d_a", u2_dout1, 16'h1001);
    step(); chk("lat2_v_b", u2_v1, 1); chk("lat2_d_b", u2_dout1, 16'h1002);
    step(); chk("lat2_v_c", u2_v1, 1); chk("lat2_d_c", u2_dout1, 16'h1003);
    step(); chk("lat2_v_end", u2_v1, 0); chk("lat2_hold", u2_dout1, 16'h1003);

    // latency 2 with reset after the second request
    rd1(1); step(); rd1(2); step();
    rst = 1; rd1(3); step();
    chk("rst_mid_v", u2_v1, 0); chk("rst_mid_d1", u2_dout1, 0);
    chk("rst_mid_d0", u2_dout0, 0); chk("rst_mid_col", u2_col, 0);
    rst = 0; idle(); step();
    chk("rst_mid_v2", u2_v1, 0);
    step(); chk("rst_mid_v3", u2_v1, 0);

    // mode 0 masked writes
    wr(3, 16'hBEEF, 2'b11); step(); idle(); rd0(3); step(); idle(); step();
    chk("m0_v", u1_v0, 1); chk("m0_beef", u1_dout0, 16'hBEEF);
    wr(3, 16'h1200, 2'b10); step(); idle(); rd0(3); step(); idle(); step();
    chk("m0_mask", u1_dout0, 16'h12EF);

    // same-cycle bypass and collision
    wr(7, 16'hA5A5, 2'b11); rd1(7); step(); idle(); step();
    chk("byp_v", u1_v1, 1); chk("byp_d", u1_dout1, 16'hA5A5); chk("byp_col", u1_col, 1);
    wr(7, 16'h5A5A, 2'b11); rd1(8); step(); idle(); step();
    chk("nocol_v", u1_v1, 1); chk("nocol_col", u1_col, 0); chk("nocol_d", u1_dout1, 16'h1008);

    // ring of 16, samples 1..20
    mode = 1; step();
    for (int k = 1; k <= 20; k++) begin
      wr(0, k, 2'b11); step(); idle();
      if (k == 15) chk("ring_ptr15", u1_wr_ptr, 15);
      if (k == 16) begin chk("ring_wrap", u1_wr_ptr, 0); chk("ring_full", u1_fill, 16); end
    end
    chk("ring_ptr_end", u1_wr_ptr, 4); chk("ring_fill_end", u1_fill, 16);
    rd1(0); step(); idle(); step(); chk("ring_d0", u1_dout1, 20);
    rd1(15); step(); idle(); step(); chk("ring_d15", u1_dout1, 5);

    // mode toggles clear pointer and fill, memory survives
    wr(0, 21, 2'b11); step(); idle(); chk("tog_ptr5", u1_wr_ptr, 5);
    mode = 0; step(); chk("tog_ptr_a", u1_wr_ptr, 0); chk("tog_fill_a", u1_fill, 0);
    mode = 1; step(); chk("tog_ptr_b", u1_wr_ptr, 0); chk("tog_fill_b", u1_fill, 0);
    mode = 0; step(); rd0(4); step(); idle(); step(); chk("tog_mem4", u1_dout0, 21);

    // ring after reset: 10,11,12 then taps
    mode = 1; rst = 1; step(); rst = 0; idle();
    chk("r_fill0", u1_fill, 0);
    wr(0, 10, 2'b11); step(); wr(0, 11, 2'b11); step(); wr(0, 12, 2'b11); step(); idle();
    rd1(2); step(); idle(); step(); chk("r_d2", u1_dout1, 10);
    rd1(3); step(); idle(); step();
    chk("r_sil_v", u1_v1, 1); chk("r_sil_d", u1_dout1, 0); chk("r_sil_col", u1_col, 0);
    wr(0, 13, 2'b11); rd1(0); step(); idle(); step();
    chk("r_byp_d", u1_dout1, 13); chk("r_byp_col", u1_col, 1);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(39) == 0) mode = ~mode;
      rst    = ($urandom_range(79) == 0);
      csb0   = ($urandom_range(3) == 0);
      web0   = $urandom_range(1);
      wmask0 = ($urandom_range(7) == 0) ? 2'b00 : 2'($urandom_range(3));
      addr0  = 4'($urandom_range(15));
      din0   = 16'($urandom);
      csb1   = ($urandom_range(3) == 0);
      addr1  = 4'($urandom_range(15));
      step();
    end
    rst = 0; idle(); step(); step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sample_delay_ram.md
Name: sample_delay_ram

Overview:
- Parametrised single-clock 1RW1R sample memory. It is the next generation of the team's OpenRAM-style 1RW1R macro model.
- Adds three things the old model lacks: a byte write mask, selectable read latency, and write-first bypass.
- Adds a circular "delay-line" mode. In this mode port 0 streams audio samples into a ring buffer and port 1 reads a tap a given number of samples in the past.
- Sits between the pedal's sample pipeline (ADC side) and the echo/reverb effect blocks.

Parameters:
- DATA_WIDTH, 16, sample/word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 14, address width; RAM_DEPTH = 2**ADDR_WIDTH.
- NUM_WMASKS, DATA_WIDTH/8, number of byte-enable bits.
- READ_LATENCY, 1, 1 or 2 cycles from request edge to dout valid. 2 adds an output register.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = addressed RAM; 1 = circular delay line.
- csb0  in  1  port 0 chip select, active low.
- web0  in  1  port 0 write enable, active low.
- wmask0  in  NUM_WMASKS  byte enables for a port 0 write; bit i covers din0[8i+7:8i].
- addr0  in  ADDR_WIDTH  port 0 address. Used for writes only when mode=0; used for reads in both modes.
- din0  in  DATA_WIDTH  write data.
- dout0  out  DATA_WIDTH  port 0 read data.
- dout0_valid  out  1  one-cycle pulse qualifying dout0.
- csb1  in  1  port 1 chip select, active low (read only).
- addr1  in  ADDR_WIDTH  mode 0: absolute address. Mode 1: delay d in samples.
- dout1  out  DATA_WIDTH  port 1 read data.
- dout1_valid  out  1  one-cycle pulse qualifying dout1.
- wr_ptr  out  ADDR_WIDTH  next ring write address (mode 1).
- fill  out  ADDR_WIDTH+1  samples written since reset or mode change; saturates at RAM_DEPTH.
- collision  out  1  one-cycle pulse: port 1 read hit the address port 0 wrote in the same cycle.

Behaviour:
- Reset (rst=1 at posedge):
  - dout0, dout1 = 0; dout0_valid, dout1_valid, collision = 0; wr_ptr = 0; fill = 0.
  - Pipeline registers are flushed, so in-flight reads never raise valid.
  - Memory contents are not cleared.
- Request cycle: inputs are sampled at posedge N.
  - Write (csb0=0, web0=0): updates only the enabled bytes at edge N.
  - Read (csb0=0, web0=1): dout0/dout0_valid appear after edge N+READ_LATENCY-1+1, i.e. valid in cycle N+1 for latency 1, N+2 for latency 2.
  - Port 1 follows the same latency.
  - Port 0 performs either a read or a write in a cycle, never both.
- Outputs: dout holds its last value when not valid; valid pulses for exactly 1 cycle per accepted read.
- Write-first bypass: a port 1 read of the address port 0 writes in the same cycle returns the merged word (new enabled bytes, old other bytes), and collision pulses alongside dout1_valid.
- wmask0=0 with a write request: no memory change and no pointer advance (mode 1). collision is still flagged if the addresses match.
- Mode 1 write:
  - Writes to wr_ptr; addr0 is ignored.
  - wr_ptr increments modulo RAM_DEPTH; RAM_DEPTH-1 wraps to 0.
  - fill increments, saturating at RAM_DEPTH.
- Mode 1 read tap:
  - With a concurrent write: W = wr_ptr, F = fill+1 (saturated).
  - Without a concurrent write: W = wr_ptr-1, F = fill.
  - Tap address = (W - d) mod RAM_DEPTH.
  - If d >= F, the read returns 0 (silence) with valid=1 and no collision.
  - d=0 with a concurrent write returns the sample being written, via bypass.
- Mode change: mode is registered. Any change clears wr_ptr and fill at the next edge. Requests in the change cycle are processed in the old mode.
- Reset asserted mid-read: the read is dropped and no valid is produced. Reset has priority over all requests.

Test Plan:
- ADDR_WIDTH=4, lat 1, mode 0: write 0xBEEF to addr 3 with mask 11; read port 0 addr 3 next cycle -> dout0=0xBEEF with dout0_valid one cycle after the read edge. Then write 0x1200 with mask 10 -> read returns 0x12EF.
- Same-cycle write 0xA5A5 to addr 7 and port 1 read of addr 7 -> dout1=0xA5A5 and collision=1 in the valid cycle. Read of addr 8 the same cycle -> collision=0.
- Mode 1, write samples 1..20 with one write per cycle to a 16-entry ring:
  - wr_ptr goes 15->0 after sample 16 and ends at 4; fill saturates at 16.
  - Then a read with d=0 and no write -> 20; d=15 -> 5.
- Mode 1 after reset:
  - Write 3 samples (10, 11, 12); read d=2 -> 10; read d=3 -> 0 (silence, valid=1).
  - Concurrent write of 13 with d=0 -> 13.
- READ_LATENCY=2: back-to-back port 1 reads of addrs 1, 2, 3 -> three consecutive valid pulses starting 2 cycles after the first request, with data in order. Assert rst in the cycle after the second request -> no further valids, all outputs 0.
- Toggle mode 1->0->1 with wr_ptr=5 -> wr_ptr=0 and fill=0 one cycle after each change; memory data at addr 4 is unchanged (read back in mode 0).
